audio_sample_fifo: RTL and testbench
====================================

AUDIO_SAMPLE_FIFO -- requirements
Module: audio_sample_fifo

Interface
REQ-001 Parameter DEPTH, default 8, sample slots; SHALL be a power of two, minimum 2.
REQ-002 Parameter WIDTH, default 32, sample bits; matches codec stream data width.
REQ-003 clock  input  1  single clock, CLOCK_50 domain; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserts immediately, releases synchronously to clock.
REQ-005 clear  input  1  synchronous flush, active-high.
REQ-006 in_data  input  WIDTH  sample from the codec ADC channel stream.
REQ-007 in_valid  input  1  upstream sample present.
REQ-008 in_ready  output  1  FIFO can accept a sample this cycle.
REQ-009 out_data  output  WIDTH  head sample presented to the cpu core (adcdata).
REQ-010 out_valid  output  1  head sample present.
REQ-011 out_ready  input  1  cpu consumes the head sample (input_ready).
REQ-012 level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 peak  output  $clog2(DEPTH)+1  highest level reached since reset or clear.

Function
REQ-014 Write SHALL occur when in_valid and in_ready are both high at a rising edge; read SHALL occur when out_valid and out_ready are both high.
REQ-015 in_ready SHALL equal (level != DEPTH), driven from registered state only, with no combinational path from in_valid or out_ready.
REQ-016 out_valid SHALL equal (level != 0), driven from registered state only.
REQ-017 FIFO SHALL be show-ahead: out_data equals the oldest stored sample while out_valid=1, and 0 while out_valid=0.
REQ-018 Latency: a sample written into an empty FIFO at edge N SHALL appear with out_valid=1 after edge N.
REQ-019 Write and read pointers SHALL each advance by one per accepted transfer and wrap from DEPTH-1 to 0.
REQ-020 Simultaneous write and read (0<level<DEPTH) SHALL leave level unchanged and advance both pointers.
REQ-021 Full: no write occurs because in_ready=0; a read in the same cycle SHALL take effect and in_ready rises on the next cycle.
REQ-022 Empty: no read occurs because out_valid=0; a write in the same cycle SHALL take effect.
REQ-023 Samples SHALL leave in the order they were accepted, bit-exact.
REQ-024 peak SHALL update to the new level whenever the new level exceeds peak.
REQ-025 clear SHALL zero both pointers, level and peak at the next edge, taking precedence over any write or read in that cycle; a sample offered in that cycle is not accepted.

Reset
REQ-026 During reset low: pointers=0, level=0, peak=0, in_ready=0, out_valid=0, out_data=0.
REQ-027 From the first edge after reset release: in_ready=1.
REQ-028 Storage array SHALL NOT be reset; its contents are never visible because of REQ-017.
REQ-029 Reset asserted mid-transfer SHALL discard all stored samples, with no partial write.

Structure
REQ-030 Shared package audio_pkg: SAMPLE_W=32, FIFO_DEPTH=8, typedef sample_t (logic [SAMPLE_W-1:0]).
REQ-031 Single module with no sub-module; storage is an internal array inferred as registers or MLAB.
REQ-032 One instance per channel, placed between audio_config from_adc_* and each cpu core.

Verification
REQ-033 Reset release, then write 0x11111111, 0x22222222, 0x33333333 with out_ready=0 -> level=3, out_data=0x11111111; with out_ready=1 they are read in order and level returns to 0.
REQ-034 Write 8 samples with out_ready=0 -> level=8, in_ready=0, a 9th in_valid is not accepted; one read -> in_ready=1 on the next cycle.
REQ-035 Continuous in_valid=1 and out_ready=1 at level=4 for 20 cycles -> level stays 4, order preserved, pointers wrap cleanly.
REQ-036 Fill to 6, drain to 1, then clear asserted together with in_valid -> level=0, peak=0, out_valid=0, and that sample is not stored.
REQ-037 Reset pulled low at level=5 mid-stream -> outputs at reset values immediately; after release, the first sample out is the first one written post-reset.
REQ-038 Random valid/ready run of 10k transfers compared against a scoreboard -> zero mismatches, level never above 8, and peak equals the observed maximum.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio stream constants and sample type.
package audio_pkg;

  localparam int unsigned SAMPLE_W   = 32;
  localparam int unsigned FIFO_DEPTH = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;

endpackage : audio_pkg

// File: rtl/audio_sample_fifo.sv
// Show-ahead sample FIFO between the codec ADC stream and a cpu core.
// All handshake and status outputs come straight from flops; the head
// sample register is refilled every cycle from storage, or bypassed from
// in_data when the slot becoming the head is the one being written.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH,
  parameter int unsigned WIDTH = SAMPLE_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   peak
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [LW-1:0]    peak_q, peak_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             wr_en_c;
  logic             rd_en_c;

  // Next-state for pointers, occupancy, peak and the registered outputs.
  always_comb begin
    wr_en_c     = in_valid & in_ready_q & ~clear;
    rd_en_c     = out_valid_q & out_ready & ~clear;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    peak_d      = peak_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    out_data_d  = '0;

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      peak_d   = '0;
    end else begin
      if (wr_en_c) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_en_c) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_en_c, rd_en_c})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (level_d > peak_q) peak_d = level_d;
    end

    in_ready_d  = (level_d != FULL_LVL);
    out_valid_d = (level_d != '0);

    // Head slot written this very edge is not in storage yet: forward it.
    if (level_d != '0) begin
      if (wr_en_c && (rd_ptr_d == wr_ptr_q)) out_data_d = in_data;
      else                                   out_data_d = mem_q[rd_ptr_d];
    end
  end

  // Control and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      peak_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      peak_q      <= peak_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Sample storage; never reset since stale slots are never presented.
  always_ff @(posedge clock) begin
    if (wr_en_c) mem_q[wr_ptr_q] <= in_data;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign level     = level_q;
  assign peak      = peak_q;

endmodule : audio_sample_fifo

// File: tb/tb_audio_sample_fifo.sv
// Directed and randomized checks for audio_sample_fifo.
module tb_audio_sample_fifo;
  import audio_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        clear;
  sample_t     in_data;
  logic        in_valid;
  logic        in_ready;
  sample_t     out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  level;
  logic [3:0]  peak;

  int n_tests = 0;
  int n_fail  = 0;

  audio_sample_fifo #(.DEPTH(8), .WIDTH(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .peak      (peak)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; clear = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    #3;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
    n_tests++; if (peak !== 4'd0) begin n_fail++; $display("FAIL reset_peak: got %0d expected 0", peak); end
    n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    step();
    reset = 1'b1;
    step();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    sample_t vals [3];
    vals[0] = 32'h11111111; vals[1] = 32'h22222222; vals[2] = 32'h33333333;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = vals[i]; in_valid = 1'b1;
      step();
      if (i == 0) begin
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL latency_valid: got %b expected 1", out_valid); end
        n_tests++; if (out_data !== vals[0]) begin n_fail++; $display("FAIL latency_data: got %h expected %h", out_data, vals[0]); end
      end
    end
    in_valid = 1'b0; in_data = '0;
    n_tests++; if (level !== 4'd3) begin n_fail++; $display("FAIL basic_level: got %0d expected 3", level); end
    n_tests++; if (out_data !== 32'h11111111) begin n_fail++; $display("FAIL basic_head: got %h expected 11111111", out_data); end
    n_tests++; if (peak !== 4'd3) begin n_fail++; $display("FAIL basic_peak: got %0d expected 3", peak); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (out_data !== vals[i]) begin n_fail++; $display("FAIL basic_order%0d: got %h expected %h", i, out_data, vals[i]); end
      step();
    end
    out_ready = 1'b0;
    n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL basic_drained_level: got %0d expected 0", level); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained_valid: got %b expected 0", out_valid); end
    n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL basic_drained_data: got %h expected 0", out_data); end
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'hA0 + 32'(i); in_valid = 1'b1;
      step();
    end
    n_tests++; if (level !== 4'd8) begin n_fail++; $display("FAIL full_level: got %0d expected 8", level); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
    n_tests++; if (peak !== 4'd8) begin n_fail++; $display("FAIL full_peak: got %0d expected 8", peak); end
    in_data = 32'hDEAD;
    step();
    n_tests++; if (level !== 4'd8) begin n_fail++; $display("FAIL full_ninth_level: got %0d expected 8", level); end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_tests++; if (level !== 4'd7) begin n_fail++; $display("FAIL full_read_level: got %0d expected 7", level); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_read_in_ready: got %b expected 1", in_ready); end
    for (int i = 1; i < 8; i++) begin
      n_tests++; if (out_data !== 32'hA0 + 32'(i)) begin n_fail++; $display("FAIL full_order%0d: got %h expected %h", i, out_data, 32'hA0 + 32'(i)); end
      step();
    end
    out_ready = 1'b0;
    n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL full_drained_level: got %0d expected 0", level); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'h100 + 32'(i); in_valid = 1'b1;
      step();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_data = 32'h104 + 32'(k);
      n_tests++; if (level !== 4'd4) begin n_fail++; $display("FAIL b2b_level%0d: got %0d expected 4", k, level); end
      n_tests++; if (out_data !== 32'h100 + 32'(k)) begin n_fail++; $display("FAIL b2b_data%0d: got %h expected %h", k, out_data, 32'h100 + 32'(k)); end
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_tests++; if (out_data !== 32'h114 + 32'(k)) begin n_fail++; $display("FAIL b2b_tail%0d: got %h expected %h", k, out_data, 32'h114 + 32'(k)); end
      step();
    end
    out_ready = 1'b0;
    n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL b2b_drained_level: got %0d expected 0", level); end
  endtask

  task automatic test_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_data = 32'h200 + 32'(i); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    out_ready = 1'b0;
    n_tests++; if (level !== 4'd1) begin n_fail++; $display("FAIL clr_pre_level: got %0d expected 1", level); end
    n_tests++; if (out_data !== 32'h205) begin n_fail++; $display("FAIL clr_pre_head: got %h expected 205", out_data); end
    clear = 1'b1; in_valid = 1'b1; in_data = 32'hBAD0BAD0;
    step();
    clear = 1'b0; in_valid = 1'b0;
    n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL clr_level: got %0d expected 0", level); end
    n_tests++; if (peak !== 4'd0) begin n_fail++; $display("FAIL clr_peak: got %0d expected 0", peak); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_out_valid: got %b expected 0", out_valid); end
    n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL clr_out_data: got %h expected 0", out_data); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL clr_in_ready: got %b expected 1", in_ready); end
    step();
    n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL clr_not_stored: got %0d expected 0", level); end
    in_data = 32'h300; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_tests++; if (out_data !== 32'h300) begin n_fail++; $display("FAIL clr_post_data: got %h expected 300", out_data); end
    n_tests++; if (peak !== 4'd1) begin n_fail++; $display("FAIL clr_post_peak: got %0d expected 1", peak); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL clr_post_drain: got %0d expected 0", level); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data = 32'h400 + 32'(i); in_valid = 1'b1;
      step();
    end
    n_tests++; if (level !== 4'd5) begin n_fail++; $display("FAIL rmid_pre_level: got %0d expected 5", level); end
    in_data = 32'h405; out_ready = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_in_ready: got %b expected 0", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %b expected 0", out_valid); end
    n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL rmid_level: got %0d expected 0", level); end
    n_tests++; if (peak !== 4'd0) begin n_fail++; $display("FAIL rmid_peak: got %0d expected 0", peak); end
    n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rmid_out_data: got %h expected 0", out_data); end
    step();
    n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL rmid_held_level: got %0d expected 0", level); end
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_release_ready: got %b expected 1", in_ready); end
    for (int i = 0; i < 2; i++) begin
      in_data = 32'h500 + 32'(i); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    n_tests++; if (level !== 4'd2) begin n_fail++; $display("FAIL rmid_post_level: got %0d expected 2", level); end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_tests++; if (out_data !== 32'h500 + 32'(i)) begin n_fail++; $display("FAIL rmid_order%0d: got %h expected %h", i, out_data, 32'h500 + 32'(i)); end
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    sample_t q [$];
    int      maxlvl = 0;
    int      reads  = 0;
    int      cycles = 0;
    logic    wr, rd;
    sample_t wd;
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_tests++; if (peak !== 4'd0) begin n_fail++; $display("FAIL rnd_start_peak: got %0d expected 0", peak); end
    while (reads < 10000 && cycles < 60000) begin
      n_tests++; if (level !== 4'(q.size())) begin n_fail++; $display("FAIL rnd_level@%0d: got %0d expected %0d", cycles, level, q.size()); end
      n_tests++; if (level > 4'd8) begin n_fail++; $display("FAIL rnd_level_bound@%0d: got %0d expected <=8", cycles, level); end
      n_tests++; if (out_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_out_valid@%0d: got %b expected %b", cycles, out_valid, q.size() != 0); end
      n_tests++; if (in_ready !== (q.size() != 8)) begin n_fail++; $display("FAIL rnd_in_ready@%0d: got %b expected %b", cycles, in_ready, q.size() != 8); end
      if (q.size() != 0) begin
        n_tests++; if (out_data !== q[0]) begin n_fail++; $display("FAIL rnd_data@%0d: got %h expected %h", cycles, out_data, q[0]); end
      end else begin
        n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rnd_empty_data@%0d: got %h expected 0", cycles, out_data); end
      end
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      in_data   = $urandom;
      wr = in_valid && (q.size() < 8);
      rd = out_ready && (q.size() > 0);
      wd = in_data;
      step();
      if (rd) begin void'(q.pop_front()); reads++; end
      if (wr) q.push_back(wd);
      if (q.size() > maxlvl) maxlvl = q.size();
      cycles++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_tests++; if (reads < 10000) begin n_fail++; $display("FAIL rnd_timeout: got %0d reads expected 10000", reads); end
    n_tests++; if (peak !== 4'(maxlvl)) begin n_fail++; $display("FAIL rnd_peak: got %0d expected %0d", peak, maxlvl); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_audio_sample_fifo
